// File: rtl/shm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shm_pkg
// Description : Shared types for the shift/mask unit arbiter. Holds the
//               operation and size encodings and the buffered request
//               record used by each requester slot.
// Revision    : 1.0 - initial release
// ============================================================================
package shm_pkg;

    // Widest destination tag the slot record can carry. Narrower tags are
    // zero-extended into it and truncated back on the way out.
    localparam int SHM_TAG_MAX_W = 16;

    // Codes 12..15 are not named here. They are still carried through the
    // arbiter without change.
    typedef enum logic [3:0] {
        SHM_SEXT   = 4'd0,
        SHM_SRL    = 4'd1,
        SHM_SRA    = 4'd2,
        SHM_SLL    = 4'd3,
        SHM_EXT_L  = 4'd4,
        SHM_EXT_H  = 4'd5,
        SHM_INS_L  = 4'd6,
        SHM_INS_H  = 4'd7,
        SHM_MSK_L  = 4'd8,
        SHM_MSK_H  = 4'd9,
        SHM_ZAP    = 4'd10,
        SHM_ZAPNOT = 4'd11
    } shm_op_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        WORD = 2'd1,
        LWRD = 2'd2,
        QWRD = 2'd3
    } op_size_e;

    typedef struct packed {
        logic [63:0]              op_a;
        logic [63:0]              op_b;
        shm_op_e                  op;
        op_size_e                 size;
        logic [SHM_TAG_MAX_W-1:0] tag;
    } shm_req_t;

endpackage : shm_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a registered pointer.
//               A lone request always wins. When both requests are present,
//               the pointer decides which one wins. After every grant the
//               pointer moves to the requester that lost. With no grant the
//               pointer holds its value.
// Ports       : clk, reset  - clock, synchronous active-high reset
//               req[1:0]    - request vector (already qualified by caller)
//               grant[1:0]  - one-hot grant, same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // Pointer value 0 means requester 0 is favoured; 1 means requester 1.
    localparam logic [0:0] c_PTR_REQ0 = 1'b0;
    localparam logic [0:0] c_PTR_REQ1 = 1'b1;

    logic [0:0] r_ptr;
    logic [0:0] w_ptr_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= c_PTR_REQ0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

    always_comb begin
        grant      = 2'b00;
        w_ptr_next = r_ptr;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_ptr == c_PTR_REQ1) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        if (grant[0]) begin
            w_ptr_next = c_PTR_REQ1;
        end else if (grant[1]) begin
            w_ptr_next = c_PTR_REQ0;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/shm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shm_arbiter
// Description : Shares one shift/mask unit between two requesters.
//               Each requester has a one-entry operand slot. Valid slots are
//               granted round-robin, one per cycle, and the granted slot
//               drives the unit in the same cycle. The unit's registered
//               result comes back one cycle later. It is routed to the
//               requester that issued the op, together with that op's tag.
// Ports       : clk, reset, flush           - clock, sync reset, kill
//               req_valid/ready, req_*      - per-requester operand intake
//               shm_enable, shm_*           - unit drive
//               shm_rvalid, shm_result      - unit return
//               rsp_valid, rsp_tag/result   - writeback
//               proto_err                   - sticky return-protocol error
//               contention_cnt              - saturating both-valid count
// Revision    : 1.0 - initial release
// ============================================================================
module shm_arbiter
    import shm_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][63:0]      req_op_a,
    input  logic [1:0][63:0]      req_op_b,
    input  logic [1:0][3:0]       req_shmsk_op,
    input  logic [1:0][1:0]       req_op_size,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic                  shm_enable,
    output logic [63:0]           shm_op_a,
    output logic [63:0]           shm_op_b,
    output logic [3:0]            shm_shmsk_op,
    output logic [1:0]            shm_op_size,
    input  logic                  shm_rvalid,
    input  logic [63:0]           shm_result,
    output logic [1:0]            rsp_valid,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [63:0]           rsp_result,
    output logic                  proto_err,
    output logic [CNT_W-1:0]      contention_cnt
);

    shm_req_t         r_slot [2];
    logic [1:0]       r_slot_vld;
    shm_req_t         w_new  [2];
    logic [1:0]       w_arb_req;
    logic [1:0]       w_grant;
    logic [1:0]       w_accept;
    logic             w_kill;
    shm_req_t         w_sel;
    logic             r_infl_vld;
    logic             r_infl_req;
    logic [TAG_W-1:0] r_infl_tag;
    logic             w_rsp_fire;
    logic             r_flush_d;
    logic             r_proto_err;
    logic [CNT_W-1:0] r_cnt;
    logic             w_unused_tag;

    // Reset takes precedence over flush. Both of them stop issue,
    // responses and intake in the cycle they are asserted.
    assign w_kill    = reset | flush;
    assign w_arb_req = r_slot_vld & {2{~w_kill}};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (w_arb_req),
        .grant (w_grant)
    );

    // A slot that is issuing this cycle can take a new operand at once.
    // While reset is asserted, both requesters see ready.
    assign req_ready = reset ? 2'b11 : ({2{~flush}} & (~r_slot_vld | w_grant));
    assign w_accept  = req_valid & req_ready & {2{~w_kill}};

    for (genvar i = 0; i < 2; i++) begin : g_pack
        assign w_new[i] = '{
            op_a: req_op_a[i],
            op_b: req_op_b[i],
            op:   shm_op_e'(req_shmsk_op[i]),
            size: op_size_e'(req_op_size[i]),
            tag:  SHM_TAG_MAX_W'(req_tag[i])
        };
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_kill) begin
                r_slot_vld[i] <= 1'b0;
            end else if (w_accept[i]) begin
                r_slot_vld[i] <= 1'b1;
                r_slot[i]     <= w_new[i];
            end else if (w_grant[i]) begin
                r_slot_vld[i] <= 1'b0;
            end
        end
    end

    // Granted slot onto the unit. All fields are zero when nothing is granted.
    always_comb begin
        w_sel = '0;
        if (w_grant[0]) begin
            w_sel = r_slot[0];
        end else if (w_grant[1]) begin
            w_sel = r_slot[1];
        end
    end

    assign shm_enable   = |w_grant;
    assign shm_op_a     = w_sel.op_a;
    assign shm_op_b     = w_sel.op_b;
    assign shm_shmsk_op = w_sel.op;
    assign shm_op_size  = w_sel.size;
    assign w_unused_tag = ^w_sel.tag;

    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_infl_vld <= 1'b0;
            r_infl_req <= 1'b0;
            r_infl_tag <= '0;
        end else begin
            r_infl_vld <= |w_grant;
            r_infl_req <= w_grant[1];
            r_infl_tag <= w_sel.tag[TAG_W-1:0];
        end
    end

    assign w_rsp_fire = r_infl_vld & shm_rvalid & ~w_kill;
    assign rsp_valid  = {w_rsp_fire & r_infl_req, w_rsp_fire & ~r_infl_req};
    assign rsp_tag    = w_rsp_fire ? r_infl_tag : '0;
    assign rsp_result = w_rsp_fire ? shm_result : '0;

    // The unit may still return a result for an op that a flush has killed.
    // That can happen in the flush cycle and in the cycle after it, so the
    // protocol check is masked in both of those cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_d   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_flush_d <= flush;
            if (!flush && !r_flush_d && (shm_rvalid != r_infl_vld)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!flush && (&r_slot_vld) && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign proto_err      = r_proto_err;
    assign contention_cnt = r_cnt;

endmodule : shm_arbiter
`default_nettype wire

// File: doc/shm_arbiter.md
SHM_ARBITER -- requirements
Module: shm_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning width of the destination-register tag.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the contention counter.
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port flush  input  1  kill all buffered and in-flight ops.
REQ-006 SHALL have ports req_valid/req_ready  input/output  [1:0]  per-requester handshake.
REQ-007 SHALL have ports req_op_a, req_op_b  input  [1:0][63:0]  operands.
REQ-008 SHALL have ports req_shmsk_op  input  [1:0][3:0] and req_op_size  input  [1:0][1:0]  operation and size.
REQ-009 SHALL have port req_tag  input  [1:0][TAG_W-1:0]  destination tag.
REQ-010 SHALL have ports shm_enable (output, 1), shm_op_a/shm_op_b (output, 64), shm_shmsk_op (output, 4), shm_op_size (output, 2)  unit drive.
REQ-011 SHALL have ports shm_rvalid (input, 1), shm_result (input, 64)  unit return, registered, 1 cycle after shm_enable.
REQ-012 SHALL have ports rsp_valid (output, [1:0]), rsp_tag (output, TAG_W), rsp_result (output, 64)  writeback.
REQ-013 SHALL have ports proto_err (output, 1) sticky and contention_cnt (output, CNT_W).

Function
REQ-014 SHALL hold one operand slot per requester; accept when req_valid[i] & req_ready[i].
REQ-015 SHALL drive req_ready[i] = ~flush & (~slot_valid[i] | grant[i]).
REQ-016 SHALL grant one valid slot per cycle; single valid slot wins; both valid -> round-robin by pointer.
REQ-017 SHALL point the round-robin pointer at the non-granted requester after every grant; pointer is unchanged with no grant.
REQ-018 SHALL, in the grant cycle, assert shm_enable and drive shm_* combinationally from the granted slot; shm_* are zero when no grant.
REQ-019 SHALL, on a grant, register in-flight state {infl_valid=1, infl_req, infl_tag}; on no grant, clear infl_valid.
REQ-020 SHALL, when infl_valid & shm_rvalid, pulse rsp_valid[infl_req] for one cycle with rsp_tag=infl_tag and rsp_result=shm_result (combinational).
REQ-021 SHALL give latency accept(N) -> issue(N+1) -> rsp(N+2) when uncontended; back-to-back issue every cycle is permitted.
REQ-022 SHALL allow a slot to refill in the same cycle it issues (simultaneous grant and accept).
REQ-023 SHALL, on flush, clear both slots and infl_valid, force shm_enable=0 and rsp_valid=0 that cycle, and accept nothing.
REQ-024 SHALL set proto_err, held until reset, whenever shm_rvalid differs from infl_valid outside a flush cycle or the cycle after a flush.
REQ-025 SHALL increment contention_cnt, saturating at all-ones, in each cycle both slots are valid and flush=0.
REQ-026 SHALL use shmsk_op encodings 0..11 (SEXT, SRL, SRA, SLL, EXT_L, EXT_H, INS_L, INS_H, MSK_L, MSK_H, ZAP, ZAPNOT) and pass codes 12..15 through unchanged.

Reset
REQ-027 SHALL, on reset, clear slots, infl_valid, proto_err and contention_cnt, and set the pointer to favor requester 0.
REQ-028 SHALL drive, during and after reset, req_ready=2'b11, shm_enable=0, rsp_valid=0, and all data outputs to zero.
REQ-029 SHALL take precedence over flush when both are asserted; a reset mid-operation discards all ops without any response.

Structure
REQ-030 SHALL place shm_op_e (4-bit enum), op_size_e (BYTE/WORD/LWRD/QWRD) and shm_req_t {op_a, op_b, op, size, tag} in package shm_pkg.
REQ-031 SHALL instantiate one sub-module, rr_arb2, as a two-way round-robin arbiter with a registered pointer.

Verification
REQ-032 SHALL check: req 0 only, SLL op_a=1 op_b=4, tag=3, accepted cycle 0 -> shm_enable cycle 1 -> rsp_valid=2'b01, tag 3, cycle 2.
REQ-033 SHALL check: both requesters valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1 and contention_cnt counts each both-valid cycle.
REQ-034 SHALL check: flush in the cycle a result returns -> rsp_valid=0, both slots empty next cycle, proto_err=0.
REQ-035 SHALL check: shm_rvalid forced 1 with no issue -> proto_err=1 the next cycle and held until reset.
REQ-036 SHALL check: contention_cnt preset near max with CNT_W=4 -> holds at 4'hF.
REQ-037 SHALL check: reset during back-to-back traffic -> no rsp_valid and all outputs zero in the following cycle.
